cvxif_offload_tracker: RTL and testbench

//  Sits between the CVA6 issue stage and the CV-X-IF coprocessor port (present when CVA6ConfigCvxifEn=1).

---
 rtl/cvxif_offload_tracker_pkg.sv | 31 +++
 rtl/cvxif_offload_tracker_if.sv | 46 ++++
 rtl/cvxif_offload_tracker_fifo.sv | 57 +++++
 rtl/cvxif_offload_tracker.sv | 128 ++++++++++++
 tb/tb_cvxif_offload_tracker.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cvxif_offload_tracker_pkg.sv
// Shared types and default sizing for the CV-X-IF offload tracker.
package cvxif_offload_tracker_pkg;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 4;
    localparam int ID_WIDTH = 3;
    localparam int INSTR_W  = 32;

    typedef logic [ID_WIDTH-1:0] id_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [2*XLEN-1:0]  rs;
        id_t                id;
    } x_issue_req_t;

    typedef struct packed {
        id_t             id;
        logic [XLEN-1:0] data;
        logic            we;
    } x_result_t;

    typedef struct packed {
        logic            valid;
        id_t             id;
        logic [XLEN-1:0] data;
        logic            we;
        logic            ex;
    } wb_t;

endpackage

// File: rtl/cvxif_offload_tracker_if.sv
// Issue-side request, X issue/result channels and writeback bundle of the offload tracker.
interface cvxif_offload_tracker_if;
    import cvxif_offload_tracker_pkg::*;

    logic                flush_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [INSTR_W-1:0]  req_instr_i;
    logic [XLEN-1:0]     req_rs1_i;
    logic [XLEN-1:0]     req_rs2_i;
    logic [ID_WIDTH-1:0] req_id_i;
    logic                x_issue_valid_o;
    logic                x_issue_ready_i;
    logic                x_issue_accept_i;
    logic [INSTR_W-1:0]  x_issue_instr_o;
    logic [2*XLEN-1:0]   x_issue_rs_o;
    logic [ID_WIDTH-1:0] x_issue_id_o;
    logic                x_result_valid_i;
    logic                x_result_ready_o;
    logic [ID_WIDTH-1:0] x_result_id_i;
    logic [XLEN-1:0]     x_result_data_i;
    logic                x_result_we_i;
    logic                wb_valid_o;
    logic [ID_WIDTH-1:0] wb_id_o;
    logic [XLEN-1:0]     wb_data_o;
    logic                wb_we_o;
    logic                wb_ex_o;
    logic                busy_o;

    modport slave (
        input  flush_i, req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_id_i,
               x_issue_ready_i, x_issue_accept_i,
               x_result_valid_i, x_result_id_i, x_result_data_i, x_result_we_i,
        output req_ready_o, x_issue_valid_o, x_issue_instr_o, x_issue_rs_o, x_issue_id_o,
               x_result_ready_o, wb_valid_o, wb_id_o, wb_data_o, wb_we_o, wb_ex_o, busy_o
    );

    modport master (
        output flush_i, req_valid_i, req_instr_i, req_rs1_i, req_rs2_i, req_id_i,
               x_issue_ready_i, x_issue_accept_i,
               x_result_valid_i, x_result_id_i, x_result_data_i, x_result_we_i,
        input  req_ready_o, x_issue_valid_o, x_issue_instr_o, x_issue_rs_o, x_issue_id_o,
               x_result_ready_o, wb_valid_o, wb_id_o, wb_data_o, wb_we_o, wb_ex_o, busy_o
    );

endinterface

// File: rtl/cvxif_offload_tracker_fifo.sv
// Request queue with a combinational head read so the issue channel sees the head with no latency.
module cvxif_offload_tracker_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        pop_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] usage_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_cnt;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (r_cnt == '0);
    assign w_push  = push_i && !w_full && !flush_i;
    assign w_pop   = pop_i && !empty_o && !flush_i;
    assign data_o  = r_mem[r_rptr];
    assign usage_o = r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/cvxif_offload_tracker.sv
// Queues offloaded instructions, issues them over CV-X-IF and retires each with exactly one writeback
// (coprocessor result or illegal-instruction exception on rejection).
module cvxif_offload_tracker
    import cvxif_offload_tracker_pkg::*;
#(
    parameter int FIFO_DEPTH = DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    cvxif_offload_tracker_if.slave  bus
);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int NUM_IDS = 2**ID_WIDTH;
    localparam int SUM_W   = ID_WIDTH + 2;

    x_issue_req_t       w_req;
    x_issue_req_t       w_head;
    x_result_t          w_res;
    wb_t                r_wb;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_fifo_cnt;
    logic [NUM_IDS-1:0] r_busy;
    logic [NUM_IDS-1:0] w_busy_next;
    logic [SUM_W-1:0]   w_busy_cnt;
    logic [SUM_W-1:0]   w_inflight;
    logic               r_rej_full;
    id_t                r_rej_id;
    logic               w_req_ready;
    logic               w_push;
    logic               w_issue_valid;
    logic               w_issue_hs;
    logic               w_set;
    logic               w_rej_load;
    logic               w_res_hit;

    assign w_req = '{instr: bus.req_instr_i, rs: {bus.req_rs2_i, bus.req_rs1_i}, id: bus.req_id_i};
    assign w_res = '{id: bus.x_result_id_i, data: bus.x_result_data_i, we: bus.x_result_we_i};

    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            w_busy_cnt = w_busy_cnt + SUM_W'(r_busy[i]);
        end
    end

    // The pending reject slot is deliberately not counted: it never blocks new requests.
    assign w_inflight  = w_busy_cnt + SUM_W'(w_fifo_cnt);
    assign w_req_ready = !rst_i && !bus.flush_i && (w_inflight < SUM_W'(FIFO_DEPTH));
    assign w_push      = bus.req_valid_i && w_req_ready;

    cvxif_offload_tracker_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     ($bits(x_issue_req_t))
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.flush_i),
        .push_i  (w_push),
        .data_i  (w_req),
        .pop_i   (w_issue_hs),
        .data_o  (w_head),
        .empty_o (w_fifo_empty),
        .usage_o (w_fifo_cnt)
    );

    // Holding issue while a reject is pending keeps the single reject slot from being overrun.
    assign w_issue_valid = !w_fifo_empty && !r_rej_full;
    assign w_issue_hs    = w_issue_valid && bus.x_issue_ready_i && !bus.flush_i;
    assign w_set         = w_issue_hs && bus.x_issue_accept_i;
    assign w_rej_load    = w_issue_hs && !bus.x_issue_accept_i;
    assign w_res_hit     = bus.x_result_valid_i && r_busy[w_res.id] && !bus.flush_i;

    for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_busy
        assign w_busy_next[gi] = bus.flush_i                                    ? 1'b0 :
                                 (w_set && (w_head.id == ID_WIDTH'(gi)))        ? 1'b1 :
                                 (w_res_hit && (w_res.id == ID_WIDTH'(gi)))     ? 1'b0 :
                                 r_busy[gi];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_busy <= '0;
        else       r_busy <= w_busy_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rej_full <= 1'b0;
            r_rej_id   <= '0;
        end else if (bus.flush_i) begin
            r_rej_full <= 1'b0;
        end else if (w_rej_load) begin
            r_rej_full <= 1'b1;
            r_rej_id   <= w_head.id;
        end else if (r_rej_full && !w_res_hit) begin
            r_rej_full <= 1'b0;
        end
    end

    // A matching result always wins the writeback slot; the reject drains on a later free cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wb <= '0;
        end else begin
            r_wb.valid <= 1'b0;
            if (!bus.flush_i) begin
                if (w_res_hit) begin
                    r_wb <= '{valid: 1'b1, id: w_res.id, data: w_res.data, we: w_res.we, ex: 1'b0};
                end else if (r_rej_full) begin
                    r_wb <= '{valid: 1'b1, id: r_rej_id, data: '0, we: 1'b0, ex: 1'b1};
                end
            end
        end
    end

    assign bus.req_ready_o      = w_req_ready;
    assign bus.x_issue_valid_o  = w_issue_valid;
    assign bus.x_issue_instr_o  = w_issue_valid ? w_head.instr : '0;
    assign bus.x_issue_rs_o     = w_issue_valid ? w_head.rs    : '0;
    assign bus.x_issue_id_o     = w_issue_valid ? w_head.id    : '0;
    assign bus.x_result_ready_o = 1'b1;
    assign bus.wb_valid_o       = r_wb.valid;
    assign bus.wb_id_o          = r_wb.id;
    assign bus.wb_data_o        = r_wb.data;
    assign bus.wb_we_o          = r_wb.we;
    assign bus.wb_ex_o          = r_wb.ex;
    assign bus.busy_o           = !w_fifo_empty || (w_busy_cnt != '0) || r_rej_full;

endmodule

// File: tb/tb_cvxif_offload_tracker.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, randomized run vs. a queue model.
module tb_cvxif_offload_tracker;
    import cvxif_offload_tracker_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cvxif_offload_tracker_if bus();

    cvxif_offload_tracker #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rv;     logic [2:0]  rid;    logic [31:0] instr;
        logic        iready; logic        acc;
        logic        resv;   logic [2:0]  resid;  logic [31:0] resdata; logic reswe;
        logic        fl;
        logic        e_ready; logic       e_iv;   logic [2:0]  e_iid;
        logic        e_wbv;  logic [2:0]  e_wbid; logic [31:0] e_wbdata;
        logic        e_wbwe; logic        e_wbex; logic        e_busy;
    } vec_t;

    typedef struct packed {
        logic [2:0]  id;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } mreq_t;

    vec_t  tbl [17];
    mreq_t mq [$];
    bit    ob [8];
    bit    rej_v;
    logic [2:0] rej_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i          = 1'b0;
        bus.req_valid_i      = 1'b0;
        bus.req_instr_i      = '0;
        bus.req_rs1_i        = '0;
        bus.req_rs2_i        = '0;
        bus.req_id_i         = '0;
        bus.x_issue_ready_i  = 1'b0;
        bus.x_issue_accept_i = 1'b0;
        bus.x_result_valid_i = 1'b0;
        bus.x_result_id_i    = '0;
        bus.x_result_data_i  = '0;
        bus.x_result_we_i    = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        bus.req_valid_i      = v.rv;
        bus.req_id_i         = v.rid;
        bus.req_instr_i      = v.instr;
        bus.req_rs1_i        = v.instr ^ 32'h0F0F_0F0F;
        bus.req_rs2_i        = ~v.instr;
        bus.x_issue_ready_i  = v.iready;
        bus.x_issue_accept_i = v.acc;
        bus.x_result_valid_i = v.resv;
        bus.x_result_id_i    = v.resid;
        bus.x_result_data_i  = v.resdata;
        bus.x_result_we_i    = v.reswe;
        bus.flush_i          = v.fl;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  64'(bus.req_ready_o),      64'd0);
        chk({tag, "_iss_valid"},  64'(bus.x_issue_valid_o),  64'd0);
        chk({tag, "_iss_instr"},  64'(bus.x_issue_instr_o),  64'd0);
        chk({tag, "_iss_rs"},     64'(bus.x_issue_rs_o),     64'd0);
        chk({tag, "_iss_id"},     64'(bus.x_issue_id_o),     64'd0);
        chk({tag, "_res_ready"},  64'(bus.x_result_ready_o), 64'd1);
        chk({tag, "_wb_valid"},   64'(bus.wb_valid_o),       64'd0);
        chk({tag, "_wb_id"},      64'(bus.wb_id_o),          64'd0);
        chk({tag, "_wb_data"},    64'(bus.wb_data_o),        64'd0);
        chk({tag, "_wb_we"},      64'(bus.wb_we_o),          64'd0);
        chk({tag, "_wb_ex"},      64'(bus.wb_ex_o),          64'd0);
        chk({tag, "_busy"},       64'(bus.busy_o),           64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // rv rid instr iready acc | resv resid resdata reswe fl | e_ready e_iv e_iid | e_wbv e_wbid e_wbdata e_wbwe e_wbex e_busy
        tbl[0]  = '{1'b1,3'd2,32'h0000_000B,1'b0,1'b0, 1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,3'd0, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[1]  = '{1'b0,3'd0,32'h0,1'b1,1'b1,          1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b1,3'd2, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[2]  = '{1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,3'd2,32'hDEAD_BEEF,1'b1,1'b0,  1'b1,1'b0,3'd0, 1'b1,3'd2,32'hDEAD_BEEF,1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b1,3'd5,32'h0000_002B,1'b0,1'b0, 1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,3'd0, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[4]  = '{1'b0,3'd0,32'h0,1'b1,1'b0,          1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b1,3'd5, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[5]  = '{1'b0,3'd0,32'h0,1'b0,1'b0,          1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,3'd0, 1'b1,3'd5,32'h0,1'b0,1'b1,1'b0};
        tbl[6]  = '{1'b1,3'd3,32'h0000_005B,1'b0,1'b0, 1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,3'd0, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[7]  = '{1'b1,3'd1,32'h0000_007B,1'b1,1'b1, 1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b1,3'd3, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[8]  = '{1'b0,3'd0,32'h0,1'b1,1'b0, 1'b1,3'd3,32'h0000_1234,1'b1,1'b0,  1'b1,1'b1,3'd1, 1'b1,3'd3,32'h0000_1234,1'b1,1'b0,1'b1};
        tbl[9]  = '{1'b0,3'd0,32'h0,1'b0,1'b0,          1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,3'd0, 1'b1,3'd1,32'h0,1'b0,1'b1,1'b0};
        tbl[10] = '{1'b1,3'd4,32'h0000_000B,1'b0,1'b0, 1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,3'd0, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[11] = '{1'b1,3'd6,32'h0000_002B,1'b1,1'b1, 1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b1,3'd4, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[12] = '{1'b0,3'd0,32'h0,1'b1,1'b0,          1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b1,3'd6, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[13] = '{1'b1,3'd0,32'h0000_003B,1'b0,1'b0, 1'b1,3'd4,32'h0000_0055,1'b0,1'b0, 1'b1,1'b0,3'd0, 1'b1,3'd4,32'h0000_0055,1'b0,1'b0,1'b1};
        tbl[14] = '{1'b0,3'd0,32'h0,1'b1,1'b1,          1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,1'b0,3'd0, 1'b1,3'd6,32'h0,1'b0,1'b1,1'b1};
        tbl[15] = '{1'b0,3'd0,32'h0,1'b1,1'b1, 1'b1,3'd7,32'h0000_0099,1'b1,1'b0,  1'b1,1'b1,3'd0, 1'b0,3'd0,32'h0,1'b0,1'b0,1'b1};
        tbl[16] = '{1'b0,3'd0,32'h0,1'b0,1'b0, 1'b1,3'd0,32'h0000_A5A5,1'b1,1'b0,  1'b1,1'b0,3'd0, 1'b1,3'd0,32'h0000_A5A5,1'b1,1'b0,1'b0};

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        #2;
        chk("post_reset_ready", 64'(bus.req_ready_o), 64'd1);

        // Directed vectors: accept/result, reject, collisions, reject gating issue, dropped result.
        for (int i = 0; i < 17; i++) begin
            apply(tbl[i]);
            #2;
            chk($sformatf("vec%0d_req_ready", i), 64'(bus.req_ready_o), 64'(tbl[i].e_ready));
            chk($sformatf("vec%0d_iss_valid", i), 64'(bus.x_issue_valid_o), 64'(tbl[i].e_iv));
            if (tbl[i].e_iv) chk($sformatf("vec%0d_iss_id", i), 64'(bus.x_issue_id_o), 64'(tbl[i].e_iid));
            tick();
            chk($sformatf("vec%0d_wb_valid", i), 64'(bus.wb_valid_o), 64'(tbl[i].e_wbv));
            if (tbl[i].e_wbv) begin
                chk($sformatf("vec%0d_wb_id", i),   64'(bus.wb_id_o),   64'(tbl[i].e_wbid));
                chk($sformatf("vec%0d_wb_data", i), 64'(bus.wb_data_o), 64'(tbl[i].e_wbdata));
                chk($sformatf("vec%0d_wb_we", i),   64'(bus.wb_we_o),   64'(tbl[i].e_wbwe));
                chk($sformatf("vec%0d_wb_ex", i),   64'(bus.wb_ex_o),   64'(tbl[i].e_wbex));
            end
            chk($sformatf("vec%0d_busy", i), 64'(bus.busy_o), 64'(tbl[i].e_busy));
            $display("vec %0d: wb_valid=%0b wb_id=%0d wb_data=%h wb_ex=%0b busy=%0b",
                     i, bus.wb_valid_o, bus.wb_id_o, bus.wb_data_o, bus.wb_ex_o, bus.busy_o);
        end
        idle();

        // Full: four requests with the coprocessor stalled.
        for (int k = 0; k < 4; k++) begin
            bus.req_valid_i = 1'b1;
            bus.req_id_i    = 3'(k);
            bus.req_instr_i = 32'h100 + 32'(k);
            #2;
            chk($sformatf("full_ready_%0d", k), 64'(bus.req_ready_o), 64'd1);
            tick();
        end
        idle();
        bus.req_valid_i = 1'b1;
        bus.req_id_i    = 3'd4;
        #2;
        chk("full_blocked", 64'(bus.req_ready_o), 64'd0);
        idle();
        bus.x_issue_ready_i  = 1'b1;
        bus.x_issue_accept_i = 1'b1;
        #2;
        chk("full_issue_id", 64'(bus.x_issue_id_o), 64'd0);
        tick();
        idle();
        #2;
        chk("full_still_blocked", 64'(bus.req_ready_o), 64'd0);
        bus.x_result_valid_i = 1'b1;
        bus.x_result_id_i    = 3'd0;
        bus.x_result_data_i  = 32'h0000_0007;
        bus.x_result_we_i    = 1'b1;
        #1;
        chk("full_same_cycle", 64'(bus.req_ready_o), 64'd0);
        tick();
        idle();
        chk("full_wb_valid", 64'(bus.wb_valid_o), 64'd1);
        chk("full_wb_id", 64'(bus.wb_id_o), 64'd0);
        #1;
        chk("full_freed", 64'(bus.req_ready_o), 64'd1);
        $display("full: retire id 0 reopened req_ready");

        // Flush: ids 2,3 queued, id 1 outstanding; flush overrides push, issue and result.
        bus.x_issue_ready_i  = 1'b1;
        bus.x_issue_accept_i = 1'b1;
        #2;
        chk("flush_pre_issue_id", 64'(bus.x_issue_id_o), 64'd1);
        tick();
        idle();
        bus.flush_i          = 1'b1;
        bus.req_valid_i      = 1'b1;
        bus.req_id_i         = 3'd5;
        bus.x_issue_ready_i  = 1'b1;
        bus.x_issue_accept_i = 1'b1;
        bus.x_result_valid_i = 1'b1;
        bus.x_result_id_i    = 3'd1;
        bus.x_result_data_i  = 32'h0000_0077;
        #2;
        chk("flush_ready", 64'(bus.req_ready_o), 64'd0);
        tick();
        chk("flush_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("flush_busy", 64'(bus.busy_o), 64'd0);
        idle();
        bus.x_result_valid_i = 1'b1;
        bus.x_result_id_i    = 3'd1;
        bus.x_result_data_i  = 32'h0000_0077;
        #2;
        chk("flush_iss_valid", 64'(bus.x_issue_valid_o), 64'd0);
        chk("flush_ready_back", 64'(bus.req_ready_o), 64'd1);
        tick();
        chk("flush_late_result", 64'(bus.wb_valid_o), 64'd0);
        idle();
        $display("flush: state cleared, late result dropped");

        // Asynchronous reset in the middle of a result cycle.
        bus.req_valid_i = 1'b1;
        bus.req_id_i    = 3'd2;
        tick();
        idle();
        bus.x_issue_ready_i  = 1'b1;
        bus.x_issue_accept_i = 1'b1;
        bus.req_valid_i      = 1'b1;
        bus.req_id_i         = 3'd3;
        tick();
        idle();
        bus.x_result_valid_i = 1'b1;
        bus.x_result_id_i    = 3'd2;
        bus.x_result_data_i  = 32'h1357_9BDF;
        bus.x_result_we_i    = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        tick();
        chk("midrst_no_wb", 64'(bus.wb_valid_o), 64'd0);
        idle();
        rst = 1'b0;
        tick();
        chk("midrst_busy", 64'(bus.busy_o), 64'd0);
        $display("reset: mid-traffic reset returned to idle");

        // Randomized run against a queue/array model.
        mq.delete();
        for (int i = 0; i < 8; i++) ob[i] = 1'b0;
        rej_v  = 1'b0;
        rej_id = 3'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          inuse [8];
            int          fid;
            int          start;
            int          occ;
            int          n_out;
            int          pick;
            bit          e_rdy;
            bit          e_iv;
            bit          e_wbv;
            bit          e_busy;
            logic [2:0]  e_id;
            logic [31:0] e_data;
            bit          e_we;
            bit          e_ex;
            mreq_t       nr;
            mreq_t       h;

            for (int i = 0; i < 8; i++) inuse[i] = ob[i];
            foreach (mq[j]) inuse[mq[j].id] = 1'b1;
            if (rej_v) inuse[rej_id] = 1'b1;
            fid   = -1;
            start = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
                if (fid < 0 && !inuse[(start + k) % 8]) fid = (start + k) % 8;
            end
            occ   = mq.size();
            n_out = 0;
            for (int i = 0; i < 8; i++) n_out += int'(ob[i]);
            occ += n_out;

            idle();
            bus.flush_i = ($urandom_range(0, 63) == 0);
            nr = '0;
            if (fid >= 0 && $urandom_range(0, 1) == 1) begin
                nr.id    = 3'(fid);
                nr.instr = $urandom;
                nr.rs1   = $urandom;
                nr.rs2   = $urandom;
                bus.req_valid_i = 1'b1;
                bus.req_id_i    = nr.id;
                bus.req_instr_i = nr.instr;
                bus.req_rs1_i   = nr.rs1;
                bus.req_rs2_i   = nr.rs2;
            end
            bus.x_issue_ready_i  = 1'($urandom_range(0, 1));
            bus.x_issue_accept_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                bus.x_result_valid_i = 1'b1;
                bus.x_result_id_i    = 3'($urandom_range(0, 7));
                if (n_out > 0 && $urandom_range(0, 3) != 0) begin
                    pick = $urandom_range(0, n_out - 1);
                    for (int i = 0; i < 8; i++) begin
                        if (ob[i]) begin
                            if (pick == 0) bus.x_result_id_i = 3'(i);
                            pick--;
                        end
                    end
                end
                bus.x_result_data_i = $urandom;
                bus.x_result_we_i   = 1'($urandom_range(0, 1));
            end

            e_rdy = (occ < DEPTH) && !bus.flush_i;
            e_iv  = (mq.size() > 0) && !rej_v;
            #2;
            chk("rand_req_ready", 64'(bus.req_ready_o), 64'(e_rdy));
            chk("rand_iss_valid", 64'(bus.x_issue_valid_o), 64'(e_iv));
            if (e_iv) begin
                chk("rand_iss_id", 64'(bus.x_issue_id_o), 64'(mq[0].id));
                chk("rand_iss_instr", 64'(bus.x_issue_instr_o), 64'(mq[0].instr));
                chk("rand_iss_rs", 64'(bus.x_issue_rs_o), {mq[0].rs2, mq[0].rs1});
            end

            e_wbv = 1'b0; e_id = '0; e_data = '0; e_we = 1'b0; e_ex = 1'b0;
            if (bus.flush_i) begin
                mq.delete();
                for (int i = 0; i < 8; i++) ob[i] = 1'b0;
                rej_v = 1'b0;
            end else begin
                if (bus.x_result_valid_i && ob[bus.x_result_id_i]) begin
                    e_wbv = 1'b1; e_id = bus.x_result_id_i; e_data = bus.x_result_data_i;
                    e_we  = bus.x_result_we_i;
                    ob[bus.x_result_id_i] = 1'b0;
                end else if (rej_v) begin
                    e_wbv = 1'b1; e_id = rej_id; e_ex = 1'b1;
                    rej_v = 1'b0;
                end
                if (e_iv && bus.x_issue_ready_i) begin
                    h = mq.pop_front();
                    if (bus.x_issue_accept_i) ob[h.id] = 1'b1;
                    else begin
                        rej_v  = 1'b1;
                        rej_id = h.id;
                    end
                end
                if (bus.req_valid_i && e_rdy) mq.push_back(nr);
            end
            e_busy = (mq.size() > 0) || rej_v;
            for (int i = 0; i < 8; i++) if (ob[i]) e_busy = 1'b1;

            tick();
            chk("rand_wb_valid", 64'(bus.wb_valid_o), 64'(e_wbv));
            if (e_wbv) begin
                chk("rand_wb_id",   64'(bus.wb_id_o),   64'(e_id));
                chk("rand_wb_data", 64'(bus.wb_data_o), 64'(e_data));
                chk("rand_wb_we",   64'(bus.wb_we_o),   64'(e_we));
                chk("rand_wb_ex",   64'(bus.wb_ex_o),   64'(e_ex));
                $display("rand cyc %0d: wb id=%0d data=%h we=%0b ex=%0b",
                         cyc, bus.wb_id_o, bus.wb_data_o, bus.wb_we_o, bus.wb_ex_o);
            end
            chk("rand_busy", 64'(bus.busy_o), 64'(e_busy));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
